// File: rtl/lsu_if.sv
// Core-side and memory-side signals of the load/store unit, bundled as one port.
// Build macro LSU_MISALIGN_CHECK_EN adds the core_misaligned_o trap signal.
interface lsu_if;

    logic        core_req_i;
    logic        core_we_i;
    logic [2:0]  core_size_i;
    logic [31:0] core_addr_i;
    logic [31:0] core_wd_i;
    logic [31:0] core_rd_o;
    logic        core_stall_o;
`ifdef LSU_MISALIGN_CHECK_EN
    logic        core_misaligned_o;
`endif

    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wd_o;
    logic [31:0] mem_rd_i;
    logic        mem_ready_i;

    // The LSU drives the *_o signals; its environment (core + memory) drives the *_i signals.
    modport master (
`ifdef LSU_MISALIGN_CHECK_EN
        output core_misaligned_o,
`endif
        input  core_req_i,
        input  core_we_i,
        input  core_size_i,
        input  core_addr_i,
        input  core_wd_i,
        output core_rd_o,
        output core_stall_o,
        output mem_req_o,
        output mem_we_o,
        output mem_be_o,
        output mem_addr_o,
        output mem_wd_o,
        input  mem_rd_i,
        input  mem_ready_i
    );

    modport slave (
`ifdef LSU_MISALIGN_CHECK_EN
        input  core_misaligned_o,
`endif
        output core_req_i,
        output core_we_i,
        output core_size_i,
        output core_addr_i,
        output core_wd_i,
        input  core_rd_o,
        input  core_stall_o,
        input  mem_req_o,
        input  mem_we_o,
        input  mem_be_o,
        input  mem_addr_o,
        input  mem_wd_o,
        output mem_rd_i,
        output mem_ready_i
    );

endinterface

// File: rtl/lsu.sv
// RV32 load/store unit: turns core requests into word-aligned memory accesses and extends load data.
// Build macro LSU_MISALIGN_CHECK_EN blocks misaligned accesses and flags them on core_misaligned_o.
module lsu (
    input  logic  clk_i,
    input  logic  rst_i,
    lsu_if.master bus
);

    localparam logic [2:0] LDST_B  = 3'd0;
    localparam logic [2:0] LDST_H  = 3'd1;
    localparam logic [2:0] LDST_W  = 3'd2;
    localparam logic [2:0] LDST_BU = 3'd4;
    localparam logic [2:0] LDST_HU = 3'd5;

    logic        stall_q;
    logic        stall_d;
    logic [1:0]  off;
    logic        blocked;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] rd;

    assign off = bus.core_addr_i[1:0];

`ifdef LSU_MISALIGN_CHECK_EN
    logic misaligned;

    // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        misaligned = 1'b0;
        case (bus.core_size_i)
            LDST_H, LDST_HU: misaligned = off[0];
            LDST_W:          misaligned = (off != 2'b00);
            default:         misaligned = 1'b0;
        endcase
    end

    assign blocked               = bus.core_req_i & misaligned;
    assign bus.core_misaligned_o = blocked;
`else
    assign blocked = 1'b0;
`endif

    // The first cycle of every access always stalls; completion needs ready seen while stall_q is set.
    always_comb begin
        stall_d = bus.core_req_i & ~blocked & ~(stall_q & bus.mem_ready_i);
    end

    // NOTE: sequential state uses non-blocking assignments; combinational logic above uses blocking.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_q <= 1'b0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign bus.core_stall_o = stall_d;
    assign bus.mem_req_o    = bus.core_req_i & ~blocked;
    assign bus.mem_we_o     = bus.core_req_i & bus.core_we_i & ~blocked;
    assign bus.mem_addr_o   = bus.core_addr_i;

    // Store lane steering; unsigned codes behave as their signed twins, undefined codes write nothing.
    always_comb begin
        be = 4'b0000;
        wd = bus.core_wd_i;
        case (bus.core_size_i)
            LDST_B, LDST_BU: begin
                be = 4'b0001 << off;
                wd = {4{bus.core_wd_i[7:0]}};
            end
            LDST_H, LDST_HU: begin
                be = 4'b0011 << {off[1], 1'b0};
                wd = {2{bus.core_wd_i[15:0]}};
            end
            LDST_W: begin
                be = 4'b1111;
                wd = bus.core_wd_i;
            end
            default: begin
                be = 4'b0000;
                wd = bus.core_wd_i;
            end
        endcase
        if (!bus.core_we_i) begin
            be = 4'b0000;
        end
    end

    assign bus.mem_be_o = be;
    assign bus.mem_wd_o = wd;

    always_comb begin
        byte_sel = bus.mem_rd_i[7:0];
        case (off)
            2'd0: byte_sel = bus.mem_rd_i[7:0];
            2'd1: byte_sel = bus.mem_rd_i[15:8];
            2'd2: byte_sel = bus.mem_rd_i[23:16];
            2'd3: byte_sel = bus.mem_rd_i[31:24];
            default: byte_sel = bus.mem_rd_i[7:0];
        endcase
        half_sel = off[1] ? bus.mem_rd_i[31:16] : bus.mem_rd_i[15:0];
    end

    always_comb begin
        rd = bus.mem_rd_i;
        case (bus.core_size_i)
            LDST_B:  rd = {{24{byte_sel[7]}}, byte_sel};
            LDST_BU: rd = {24'h000000, byte_sel};
            LDST_H:  rd = {{16{half_sel[15]}}, half_sel};
            LDST_HU: rd = {16'h0000, half_sel};
            LDST_W:  rd = bus.mem_rd_i;
            default: rd = bus.mem_rd_i;
        endcase
    end

    assign bus.core_rd_o = rd;

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed scenarios plus randomized accesses against a spec-level model.
// Build with LSU_MISALIGN_CHECK_EN to also exercise the misalignment trap.
module tb_lsu;

    localparam logic [2:0] LDST_B  = 3'd0;
    localparam logic [2:0] LDST_H  = 3'd1;
    localparam logic [2:0] LDST_W  = 3'd2;
    localparam logic [2:0] LDST_BU = 3'd4;
    localparam logic [2:0] LDST_HU = 3'd5;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fails  = 0;

    lsu_if bus ();

    lsu u_dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] model_be(input logic we, input logic [2:0] size, input logic [31:0] addr);
        int off;
        off = int'(addr & 32'h3);
        if (!we) return 4'b0000;
        case (size)
            LDST_B, LDST_BU: return 4'(1 << off);
            LDST_H, LDST_HU: return 4'(3 << (2 * (off / 2)));
            LDST_W:          return 4'hF;
            default:         return 4'h0;
        endcase
    endfunction

    function automatic logic [31:0] model_wd(input logic [2:0] size, input logic [31:0] wdata);
        case (size)
            LDST_B, LDST_BU: return (wdata & 32'hFF) * 32'h01010101;
            LDST_H, LDST_HU: return (wdata & 32'hFFFF) * 32'h00010001;
            default:         return wdata;
        endcase
    endfunction

    function automatic logic [31:0] model_rd(input logic [2:0] size, input logic [31:0] addr, input logic [31:0] rdata);
        int off;
        logic [31:0] b;
        logic [31:0] h;
        off = int'(addr & 32'h3);
        b = (rdata >> (8 * off)) & 32'hFF;
        h = (rdata >> (16 * (off / 2))) & 32'hFFFF;
        case (size)
            LDST_B:  return (b >= 32'd128)   ? b - 32'd256   : b;
            LDST_BU: return b;
            LDST_H:  return (h >= 32'd32768) ? h - 32'd65536 : h;
            LDST_HU: return h;
            default: return rdata;
        endcase
    endfunction

    function automatic logic model_mis(input logic [2:0] size, input logic [31:0] addr);
`ifdef LSU_MISALIGN_CHECK_EN
        int off;
        off = int'(addr & 32'h3);
        if (size == LDST_H || size == LDST_HU) return (off % 2) != 0;
        if (size == LDST_W) return off != 0;
        return 1'b0;
`else
        return (size == 3'd7) && (addr == 32'hFFFF_FFFF) && 1'b0;
`endif
    endfunction

    // Drives one access to completion; mem_ready_i is low for wait_cycles cycles after the first one.
    task automatic run_access(
        input  logic        we,
        input  logic [2:0]  size,
        input  logic [31:0] addr,
        input  logic [31:0] wdata,
        input  logic [31:0] rdata,
        input  int          wait_cycles,
        output int          stall_cycles,
        output logic [31:0] rd_obs,
        output logic        req0,
        output logic        we0,
        output logic [3:0]  be0,
        output logic [31:0] wd0,
        output logic [31:0] addr0,
        output logic        mis0,
        output logic        timed_out
    );
        int cyc;
        cyc          = 0;
        stall_cycles = 0;
        timed_out    = 1'b0;
        rd_obs       = 32'h0;
        mis0         = 1'b0;
        req0         = 1'b0;
        we0          = 1'b0;
        be0          = 4'h0;
        wd0          = 32'h0;
        addr0        = 32'h0;
        while (1) begin
            @(negedge clk);
            bus.core_req_i  = 1'b1;
            bus.core_we_i   = we;
            bus.core_size_i = size;
            bus.core_addr_i = addr;
            bus.core_wd_i   = wdata;
            bus.mem_rd_i    = rdata;
            bus.mem_ready_i = (cyc == 0) ? 1'($urandom) : (cyc > wait_cycles);
            #1;
            if (cyc == 0) begin
                req0  = bus.mem_req_o;
                we0   = bus.mem_we_o;
                be0   = bus.mem_be_o;
                wd0   = bus.mem_wd_o;
                addr0 = bus.mem_addr_o;
`ifdef LSU_MISALIGN_CHECK_EN
                mis0  = bus.core_misaligned_o;
`endif
            end
            if (!bus.core_stall_o) begin
                rd_obs = bus.core_rd_o;
                break;
            end
            stall_cycles++;
            cyc++;
            if (cyc > 64) begin
                timed_out = 1'b1;
                break;
            end
        end
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        bus.core_req_i  = 1'b0;
        bus.core_we_i   = 1'b0;
        bus.mem_ready_i = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst             = 1'b1;
        bus.core_req_i  = 1'b1;
        bus.core_we_i   = 1'b0;
        bus.core_size_i = LDST_W;
        bus.core_addr_i = 32'h0;
        bus.core_wd_i   = 32'h0;
        bus.mem_rd_i    = 32'h0;
        bus.mem_ready_i = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if (bus.core_stall_o !== 1'b1) begin
            n_fails++;
            $display("FAIL reset_hold_stall: got %b expected 1", bus.core_stall_o);
        end
        @(negedge clk);
        rst            = 1'b0;
        bus.core_req_i = 1'b0;
        #1;
        n_checks++;
        if (bus.core_stall_o !== 1'b0 || bus.mem_req_o !== 1'b0 || bus.mem_we_o !== 1'b0) begin
            n_fails++;
            $display("FAIL reset_idle: got stall=%b req=%b we=%b expected 0/0/0",
                     bus.core_stall_o, bus.mem_req_o, bus.mem_we_o);
        end
        @(negedge clk);
        bus.core_req_i = 1'b1;
        #1;
        n_checks++;
        if (bus.core_stall_o !== 1'b1) begin
            n_fails++;
            $display("FAIL reset_first_cycle: got stall=%b expected 1", bus.core_stall_o);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (bus.core_stall_o !== 1'b0) begin
            n_fails++;
            $display("FAIL reset_complete: got stall=%b expected 0", bus.core_stall_o);
        end
        idle_cycle();
    endtask

    task automatic test_store();
        int sc; logic [31:0] rdo; logic rq, wq, mis, to; logic [3:0] be; logic [31:0] wd, ad;
        run_access(1'b1, LDST_W, 32'h10, 32'hDEADBEEF, 32'h0, 0, sc, rdo, rq, wq, be, wd, ad, mis, to);
        n_checks++;
        if (to || sc != 1 || be !== 4'b1111 || wd !== 32'hDEADBEEF || rq !== 1'b1 || wq !== 1'b1 || ad !== 32'h10) begin
            n_fails++;
            $display("FAIL store_sw: got to=%b stalls=%0d be=%b wd=%h req=%b we=%b addr=%h expected 0/1/1111/deadbeef/1/1/10",
                     to, sc, be, wd, rq, wq, ad);
        end
        idle_cycle();
        n_checks++;
        if (bus.mem_req_o !== 1'b0 || bus.core_stall_o !== 1'b0) begin
            n_fails++;
            $display("FAIL store_release: got req=%b stall=%b expected 0/0", bus.mem_req_o, bus.core_stall_o);
        end
        run_access(1'b1, LDST_B, 32'h13, 32'h000000A5, 32'h0, 1, sc, rdo, rq, wq, be, wd, ad, mis, to);
        n_checks++;
        if (to || sc != 2 || be !== 4'b1000 || wd !== 32'hA5A5A5A5) begin
            n_fails++;
            $display("FAIL store_sb: got stalls=%0d be=%b wd=%h expected 2/1000/a5a5a5a5", sc, be, wd);
        end
        run_access(1'b1, LDST_H, 32'h12, 32'h00001234, 32'h0, 0, sc, rdo, rq, wq, be, wd, ad, mis, to);
        n_checks++;
        if (to || sc != 1 || be !== 4'b1100 || wd !== 32'h12341234) begin
            n_fails++;
            $display("FAIL store_sh: got stalls=%0d be=%b wd=%h expected 1/1100/12341234", sc, be, wd);
        end
        idle_cycle();
    endtask

    task automatic test_load();
        logic [2:0]  sizes [5] = '{LDST_B, LDST_BU, LDST_H, LDST_HU, LDST_W};
        logic [31:0] addrs [5] = '{32'h22, 32'h23, 32'h22, 32'h20, 32'h20};
        logic [31:0] exps  [5] = '{32'hFFFFFFFF, 32'h00000080, 32'hFFFF80FF, 32'h00007F01, 32'h80FF7F01};
        int sc; logic [31:0] rdo; logic rq, wq, mis, to; logic [3:0] be; logic [31:0] wd, ad;
        for (int i = 0; i < 5; i++) begin
            int w;
            w = int'($urandom_range(0, 2));
            run_access(1'b0, sizes[i], addrs[i], 32'h0, 32'h80FF7F01, w, sc, rdo, rq, wq, be, wd, ad, mis, to);
            n_checks++;
            if (to || sc != w + 1 || rdo !== exps[i] || be !== 4'b0000 || wq !== 1'b0 || rq !== 1'b1) begin
                n_fails++;
                $display("FAIL load_%0d: got stalls=%0d rd=%h be=%b we=%b req=%b expected %0d/%h/0000/0/1",
                         i, sc, rdo, be, wq, rq, w + 1, exps[i]);
            end
        end
        idle_cycle();
    endtask

    task automatic test_back_to_back();
        int sc; logic [31:0] rdo; logic rq, wq, mis, to; logic [3:0] be; logic [31:0] wd, ad;
        run_access(1'b0, LDST_W, 32'h40, 32'h0, 32'h01234567, 3, sc, rdo, rq, wq, be, wd, ad, mis, to);
        n_checks++;
        if (to || sc != 4 || rdo !== 32'h01234567) begin
            n_fails++;
            $display("FAIL wait_stall: got stalls=%0d rd=%h expected 4/01234567", sc, rdo);
        end
        run_access(1'b1, LDST_W, 32'h44, 32'hCAFEF00D, 32'h0, 0, sc, rdo, rq, wq, be, wd, ad, mis, to);
        n_checks++;
        if (to || sc != 1 || wd !== 32'hCAFEF00D) begin
            n_fails++;
            $display("FAIL back_to_back: got stalls=%0d wd=%h expected 1/cafef00d", sc, wd);
        end
        idle_cycle();
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        bus.core_req_i  = 1'b1;
        bus.core_we_i   = 1'b0;
        bus.core_size_i = LDST_HU;
        bus.core_addr_i = 32'h52;
        bus.mem_rd_i    = 32'hBEEF0000;
        bus.mem_ready_i = 1'b0;
        #1;
        n_checks++;
        if (bus.core_stall_o !== 1'b1) begin
            n_fails++;
            $display("FAIL rstmid_c0: got stall=%b expected 1", bus.core_stall_o);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++;
        if (bus.core_stall_o !== 1'b1) begin
            n_fails++;
            $display("FAIL rstmid_c1: got stall=%b expected 1", bus.core_stall_o);
        end
        @(negedge clk);
        rst             = 1'b0;
        bus.mem_ready_i = 1'b1;
        #1;
        n_checks++;
        if (bus.core_stall_o !== 1'b1) begin
            n_fails++;
            $display("FAIL rstmid_restart: got stall=%b expected 1", bus.core_stall_o);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (bus.core_stall_o !== 1'b0 || bus.core_rd_o !== 32'h0000BEEF) begin
            n_fails++;
            $display("FAIL rstmid_done: got stall=%b rd=%h expected 0/0000beef", bus.core_stall_o, bus.core_rd_o);
        end
        idle_cycle();
    endtask

`ifdef LSU_MISALIGN_CHECK_EN
    task automatic test_misalign();
        @(negedge clk);
        bus.core_req_i  = 1'b1;
        bus.core_we_i   = 1'b0;
        bus.core_size_i = LDST_W;
        bus.core_addr_i = 32'h6;
        bus.mem_rd_i    = 32'h11223344;
        bus.mem_ready_i = 1'b1;
        #1;
        n_checks++;
        if (bus.core_misaligned_o !== 1'b1 || bus.mem_req_o !== 1'b0 || bus.core_stall_o !== 1'b0) begin
            n_fails++;
            $display("FAIL misalign_lw: got mis=%b req=%b stall=%b expected 1/0/0",
                     bus.core_misaligned_o, bus.mem_req_o, bus.core_stall_o);
        end
        @(negedge clk);
        bus.core_size_i = LDST_H;
        #1;
        n_checks++;
        if (bus.core_misaligned_o !== 1'b0 || bus.mem_req_o !== 1'b1 || bus.core_stall_o !== 1'b1) begin
            n_fails++;
            $display("FAIL misalign_lh: got mis=%b req=%b stall=%b expected 0/1/1",
                     bus.core_misaligned_o, bus.mem_req_o, bus.core_stall_o);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (bus.core_stall_o !== 1'b0 || bus.core_rd_o !== 32'h00001122) begin
            n_fails++;
            $display("FAIL misalign_lh_done: got stall=%b rd=%h expected 0/00001122", bus.core_stall_o, bus.core_rd_o);
        end
        idle_cycle();
    endtask
`endif

    task automatic test_random();
        logic [2:0] store_sizes [5] = '{LDST_B, LDST_H, LDST_W, LDST_BU, LDST_HU};
        int sc; logic [31:0] rdo; logic rq, wq, mis, to; logic [3:0] be; logic [31:0] wd, ad;
        for (int i = 0; i < 60; i++) begin
            logic        we;
            logic [2:0]  size;
            logic [31:0] addr, wdata, rdata;
            logic        emis;
            int          w, exp_sc;
            we    = 1'($urandom);
            size  = we ? store_sizes[$urandom_range(0, 4)] : 3'($urandom);
            addr  = $urandom;
            wdata = $urandom;
            rdata = $urandom;
            w     = int'($urandom_range(0, 3));
            emis  = model_mis(size, addr);
            exp_sc = emis ? 0 : w + 1;
            run_access(we, size, addr, wdata, rdata, w, sc, rdo, rq, wq, be, wd, ad, mis, to);
            n_checks++;
            if (to || sc != exp_sc || mis !== emis || rq !== !emis || wq !== (we & !emis) || ad !== addr) begin
                n_fails++;
                $display("FAIL rand_%0d_ctrl: got to=%b stalls=%0d mis=%b req=%b we=%b addr=%h expected %0d/%b/%b/%b/%h",
                         i, to, sc, mis, rq, wq, ad, exp_sc, emis, !emis, we & !emis, addr);
            end
            if (!emis) begin
                n_checks++;
                if (be !== model_be(we, size, addr)) begin
                    n_fails++;
                    $display("FAIL rand_%0d_be: got %b expected %b", i, be, model_be(we, size, addr));
                end
                n_checks++;
                if (we && wd !== model_wd(size, wdata)) begin
                    n_fails++;
                    $display("FAIL rand_%0d_wd: got %h expected %h", i, wd, model_wd(size, wdata));
                end else if (!we && rdo !== model_rd(size, addr, rdata)) begin
                    n_fails++;
                    $display("FAIL rand_%0d_rd: got %h expected %h", i, rdo, model_rd(size, addr, rdata));
                end
            end
            if ($urandom_range(0, 1) == 0) idle_cycle();
        end
        idle_cycle();
    endtask

    initial begin
        test_reset();
        test_store();
        test_load();
        test_back_to_back();
        test_reset_mid();
`ifdef LSU_MISALIGN_CHECK_EN
        test_misalign();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
